ddr_arbiter: RTL and testbench
==============================

# ddr_arbiter

Two-port arbiter that shares the single DDR master request interface between the data cache (port 0) and the instruction cache / program loader (port 1). It sits between both cache controllers and `ddr_master`, and forwards exactly one transaction at a time: one write, or one read address plus its data beat. Between ports it grants round-robin. Within a port, a pending write always goes before a pending read, so a writeback always lands ahead of the refill of the same line.

## Interface
- `ADDR_W`, default 27: byte address width, 16-byte line aligned.
- `DATA_W`, default 128: line width.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `pN_wr_addr` in ADDR_W, `pN_wr_data` in DATA_W, `pN_wr_valid` in 1, `pN_wr_ready` out 1: port N write request (N = 0, 1).
- `pN_rd_addr` in ADDR_W, `pN_rd_avalid` in 1, `pN_rd_aready` out 1: port N read address.
- `pN_rd_data` out DATA_W, `pN_rd_valid` out 1, `pN_rd_dready` in 1: port N read data.
- `m_wr_addr` out ADDR_W, `m_wr_data` out DATA_W, `m_wr_valid` out 1, `m_wr_ready` in 1: write channel to `ddr_master`.
- `m_rd_addr` out ADDR_W, `m_rd_avalid` out 1, `m_rd_aready` in 1: read address channel to `ddr_master`.
- `m_rd_data` in DATA_W, `m_rd_valid` in 1, `m_rd_dready` out 1: read data channel from `ddr_master`.
- `busy` out 1: high in any state other than IDLE.
- `grant` out 1: port currently owning the master. Meaningful only while `busy` is high.

## Operation
- **Registers.**
  - `state` ∈ {IDLE, W_REQ, W_WAIT, R_REQ, R_DATA}.
  - `grant`.
  - `last`: port served most recently.
- **Arbitration in IDLE.** Port N is pending if `pN_wr_valid | pN_rd_avalid`.
  - If both ports are pending, the winner is `~last`.
  - Otherwise the winner is the single pending port.
  - The winner is registered into `grant` and `last` together.
  - If the winner has `wr_valid` set, next state is W_REQ; otherwise R_REQ.
- **W_REQ.**
  - `m_wr_valid`, `m_wr_addr` and `m_wr_data` mirror the granted port.
  - `pG_wr_ready` equals `m_wr_ready`.
  - When `m_wr_valid & m_wr_ready`, go to W_WAIT.
- **W_WAIT.**
  - `m_wr_valid` is 0.
  - The write is complete on the first cycle with `m_wr_ready` = 1, counted from the cycle after acceptance.
  - On completion, go to IDLE.
- **R_REQ.**
  - `m_rd_avalid` and `m_rd_addr` mirror the granted port.
  - `pG_rd_aready` equals `m_rd_aready`.
  - On the handshake, go to R_DATA.
- **R_DATA.**
  - `m_rd_dready` equals `pG_rd_dready`.
  - `pG_rd_valid` equals `m_rd_valid`.
  - `pG_rd_data` equals `m_rd_data`.
  - On `m_rd_valid & m_rd_dready`, go to IDLE.
- **Non-granted port.** All of its ready and valid outputs are 0. Its `pN_rd_data` is driven with `m_rd_data`; its value is don't-care.
- **Outputs outside W_REQ / R_REQ.** All `m_*valid` outputs are 0, except `m_rd_dready`, which is active only in R_DATA.
- **Write-then-read on one port.** A port that raises write and read together is served as two grants: write first, then read. `last` stays on that port, so when the write finishes the other port wins if it is pending. The read waits for a later grant.
- **Requester obligation.** Valid, address and data stay stable until the handshake. The arbiter does not latch address or data.

## Timing
- **Reset.**
  - `state` = IDLE, `grant` = 0, `last` = 1, so port 0 wins the first contention.
  - Every ready/valid output is 0 and `busy` = 0.
  - A reset asserted mid-transaction aborts it. `ddr_master` shares `rst` and is reset at the same time.
- **Latency.**
  - A request present in IDLE at cycle t gives `m_*valid` = 1 at cycle t+1.
  - Minimum write occupancy: 3 cycles (IDLE, W_REQ, W_WAIT).
  - Minimum read occupancy: 3 cycles (IDLE, R_REQ, R_DATA).
  - After completion the arbiter spends at least 1 idle cycle before the next grant.
- **Combinational paths.** The `m_*` / `pN_*` pass-through paths are combinational. No bubble is inserted inside a handshake.
- **Fairness.** Under continuous requests from both ports, grants strictly alternate 0, 1, 0, 1, …

## Test plan
- **Write then refill on port 0.** Port 0 raises wr (addr 0x0000120) and rd (addr 0x0000340) together; port 1 is idle.
  - Master sees the write at 0x0000120, then the write completion, then the read at 0x0000340.
  - Port 0 receives rd_data 128'hDEAD…BEEF.
  - `busy` drops once, in the idle cycle between the two grants.
- **Contention after reset.** Both ports raise reads at the same cycle.
  - Port 0 is granted first and port 1 is granted immediately after.
  - Port 1's `rd_valid` stays 0 throughout port 0's transaction.
- **Fairness.** Both ports hold reads continuously for 8 transactions.
  - Grant sequence is 0, 1, 0, 1, 0, 1, 0, 1.
- **Slow master.**
  - `m_rd_aready` delayed 5 cycles: `m_rd_avalid` and `m_rd_addr` stay stable, and `pG_rd_aready` pulses only on the handshake cycle.
  - `m_wr_ready` held low 10 cycles after a write acceptance: state remains W_WAIT until `m_wr_ready` returns to 1.
- **Reset in R_DATA.** `rst` pulses while the arbiter waits in R_DATA.
  - Next cycle: `busy` = 0, all `m_*valid` = 0, and `m_rd_dready` = 0.
  - A fresh port 1 read is then granted and completes normally.

Source files
------------

// File: rtl/ddr_arbiter.sv
// ddr_arbiter
// Shares the single ddr_master request interface between two requesters:
// port 0 (data cache) and port 1 (instruction cache / program loader).
// Exactly one transaction is in flight at a time: either one write, or one
// read address followed by its single data beat.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   pN_wr_*               : port N write request (addr, data, valid/ready)
//   pN_rd_addr/avalid/aready : port N read address channel
//   pN_rd_data/valid/dready  : port N read data channel
//   m_wr_*                : write channel to ddr_master
//   m_rd_addr/avalid/aready  : read address channel to ddr_master
//   m_rd_data/valid/dready   : read data channel from ddr_master
//   busy                  : high whenever a transaction owns the master
//   grant                 : owning port, meaningful only while busy
//
// Between ports the grant is round-robin. Within a port a pending write wins
// over a pending read, so a dirty writeback reaches memory before the refill
// of the same line. Address and data are not latched; requesters hold them
// stable until their handshake, and all data paths are combinational.
module ddr_arbiter #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] p0_wr_addr,
    input  logic [DATA_W-1:0] p0_wr_data,
    input  logic              p0_wr_valid,
    output logic              p0_wr_ready,
    input  logic [ADDR_W-1:0] p0_rd_addr,
    input  logic              p0_rd_avalid,
    output logic              p0_rd_aready,
    output logic [DATA_W-1:0] p0_rd_data,
    output logic              p0_rd_valid,
    input  logic              p0_rd_dready,

    input  logic [ADDR_W-1:0] p1_wr_addr,
    input  logic [DATA_W-1:0] p1_wr_data,
    input  logic              p1_wr_valid,
    output logic              p1_wr_ready,
    input  logic [ADDR_W-1:0] p1_rd_addr,
    input  logic              p1_rd_avalid,
    output logic              p1_rd_aready,
    output logic [DATA_W-1:0] p1_rd_data,
    output logic              p1_rd_valid,
    input  logic              p1_rd_dready,

    output logic [ADDR_W-1:0] m_wr_addr,
    output logic [DATA_W-1:0] m_wr_data,
    output logic              m_wr_valid,
    input  logic              m_wr_ready,
    output logic [ADDR_W-1:0] m_rd_addr,
    output logic              m_rd_avalid,
    input  logic              m_rd_aready,
    input  logic [DATA_W-1:0] m_rd_data,
    input  logic              m_rd_valid,
    output logic              m_rd_dready,

    output logic              busy,
    output logic              grant
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_REQ  = 3'd1,
        W_WAIT = 3'd2,
        R_REQ  = 3'd3,
        R_DATA = 3'd4
    } state_t;

    state_t state_reg;
    logic   grant_reg;
    logic   last_reg;

    // Per-port request bundles indexed by port number.
    logic [1:0] wr_valid_v;
    logic [1:0] rd_avalid_v;
    logic [1:0] rd_dready_v;
    logic [1:0] pending_v;
    logic [1:0] wr_ready_v;
    logic [1:0] rd_aready_v;
    logic [1:0] rd_valid_v;

    assign wr_valid_v  = {p1_wr_valid, p0_wr_valid};
    assign rd_avalid_v = {p1_rd_avalid, p0_rd_avalid};
    assign rd_dready_v = {p1_rd_dready, p0_rd_dready};
    assign pending_v   = wr_valid_v | rd_avalid_v;

    // Round-robin pick: on contention the port not served last wins,
    // otherwise whichever single port is pending.
    logic winner;
    assign winner = (&pending_v) ? ~last_reg : pending_v[1];

    logic in_w_req;
    logic in_w_wait;
    logic in_r_req;
    logic in_r_data;
    assign in_w_req  = (state_reg == W_REQ);
    assign in_w_wait = (state_reg == W_WAIT);
    assign in_r_req  = (state_reg == R_REQ);
    assign in_r_data = (state_reg == R_DATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            grant_reg <= 1'b0;
            last_reg  <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|pending_v) begin
                        grant_reg <= winner;
                        last_reg  <= winner;
                        state_reg <= wr_valid_v[winner] ? W_REQ : R_REQ;
                    end
                end
                W_REQ: begin
                    if (m_wr_valid && m_wr_ready) begin
                        state_reg <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    // First ready after acceptance marks write completion.
                    if (m_wr_ready) begin
                        state_reg <= IDLE;
                    end
                end
                R_REQ: begin
                    if (m_rd_avalid && m_rd_aready) begin
                        state_reg <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (m_rd_valid && m_rd_dready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Master-side pass-through. Address/data mirror the granted port at all
    // times; only the valid/ready qualifiers are gated by state.
    assign m_wr_valid  = in_w_req && wr_valid_v[grant_reg];
    assign m_wr_addr   = grant_reg ? p1_wr_addr : p0_wr_addr;
    assign m_wr_data   = grant_reg ? p1_wr_data : p0_wr_data;
    assign m_rd_avalid = in_r_req && rd_avalid_v[grant_reg];
    assign m_rd_addr   = grant_reg ? p1_rd_addr : p0_rd_addr;
    assign m_rd_dready = in_r_data && rd_dready_v[grant_reg];

    // Requester-side handshakes: only the granted port ever sees a ready
    // or valid; the other port's outputs stay at 0.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic owns;
            assign owns            = (grant_reg == 1'(gi));
            assign wr_ready_v[gi]  = in_w_req  && owns && m_wr_ready;
            assign rd_aready_v[gi] = in_r_req  && owns && m_rd_aready;
            assign rd_valid_v[gi]  = in_r_data && owns && m_rd_valid;
        end
    endgenerate

    assign p0_wr_ready  = wr_ready_v[0];
    assign p1_wr_ready  = wr_ready_v[1];
    assign p0_rd_aready = rd_aready_v[0];
    assign p1_rd_aready = rd_aready_v[1];
    assign p0_rd_valid  = rd_valid_v[0];
    assign p1_rd_valid  = rd_valid_v[1];

    // Read data fans out to both ports; only the qualified one is consumed.
    assign p0_rd_data = m_rd_data;
    assign p1_rd_data = m_rd_data;

    assign busy  = in_w_req || in_w_wait || in_r_req || in_r_data;
    assign grant = grant_reg;

endmodule

// File: tb/tb_ddr_arbiter.sv
// Testbench for ddr_arbiter: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a transaction-level
// model of the arbiter held in this bench.
module tb_ddr_arbiter;

    localparam int AW = 27;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Requester-side stimulus, indexed by port.
    logic [1:0]    wr_valid, rd_avalid, rd_dready;
    logic [AW-1:0] wr_addr [2];
    logic [AW-1:0] rd_addr [2];
    logic [DW-1:0] wr_data [2];

    logic          p0_wr_ready, p1_wr_ready, p0_rd_aready, p1_rd_aready;
    logic          p0_rd_valid, p1_rd_valid;
    logic [DW-1:0] p0_rd_data, p1_rd_data;

    logic [AW-1:0] m_wr_addr, m_rd_addr;
    logic [DW-1:0] m_wr_data, m_rd_data;
    logic          m_wr_valid, m_wr_ready, m_rd_avalid, m_rd_aready;
    logic          m_rd_valid, m_rd_dready, busy, grant;

    logic [1:0] wr_ready_v, rd_aready_v, rd_valid_v;
    assign wr_ready_v  = {p1_wr_ready, p0_wr_ready};
    assign rd_aready_v = {p1_rd_aready, p0_rd_aready};
    assign rd_valid_v  = {p1_rd_valid, p0_rd_valid};

    ddr_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .p0_wr_addr(wr_addr[0]), .p0_wr_data(wr_data[0]), .p0_wr_valid(wr_valid[0]),
        .p0_wr_ready(p0_wr_ready),
        .p0_rd_addr(rd_addr[0]), .p0_rd_avalid(rd_avalid[0]), .p0_rd_aready(p0_rd_aready),
        .p0_rd_data(p0_rd_data), .p0_rd_valid(p0_rd_valid), .p0_rd_dready(rd_dready[0]),
        .p1_wr_addr(wr_addr[1]), .p1_wr_data(wr_data[1]), .p1_wr_valid(wr_valid[1]),
        .p1_wr_ready(p1_wr_ready),
        .p1_rd_addr(rd_addr[1]), .p1_rd_avalid(rd_avalid[1]), .p1_rd_aready(p1_rd_aready),
        .p1_rd_data(p1_rd_data), .p1_rd_valid(p1_rd_valid), .p1_rd_dready(rd_dready[1]),
        .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data), .m_wr_valid(m_wr_valid),
        .m_wr_ready(m_wr_ready),
        .m_rd_addr(m_rd_addr), .m_rd_avalid(m_rd_avalid), .m_rd_aready(m_rd_aready),
        .m_rd_data(m_rd_data), .m_rd_valid(m_rd_valid), .m_rd_dready(m_rd_dready),
        .busy(busy), .grant(grant)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Transaction-level model: is a transaction open, who owns it, is it a
    // read or a write, and has its request phase been accepted yet.
    bit mb      = 1'b0;
    int mo      = 0;
    bit mk_read = 1'b0;
    bit ms_acc  = 1'b0;
    bit ml      = 1'b1;
    int comps   = 0;

    // Handshakes observed at the last sample, used by the requester agents.
    logic [1:0] wr_hs, rd_ahs, rd_dhs;
    logic       rst_s;
    logic [1:0] waiting;
    bit         rnd_mode = 1'b0;
    bit         auto_rd  = 1'b0;
    logic       busy_prev = 1'b0;
    int         gq[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sample at the falling edge: compare against the model, log grants,
    // then advance the model with the inputs in effect for the next edge.
    task automatic sample();
        bit e_wreq, e_rreq, e_rdat;
        bit p0, p1;
        int w;
        @(negedge clk);
        rst_s  = rst;
        wr_hs  = rst ? 2'b00 : (wr_valid & wr_ready_v);
        rd_ahs = rst ? 2'b00 : (rd_avalid & rd_aready_v);
        rd_dhs = rst ? 2'b00 : (rd_dready & rd_valid_v);

        e_wreq = mb && !mk_read && !ms_acc;
        e_rreq = mb && mk_read && !ms_acc;
        e_rdat = mb && mk_read && ms_acc;
        chk("busy", busy, mb);
        if (mb) chk("grant", grant, mo);
        chk("m_wr_valid", m_wr_valid, e_wreq ? wr_valid[mo] : 1'b0);
        if (e_wreq) begin
            chk("m_wr_addr", m_wr_addr, wr_addr[mo]);
            chk("m_wr_data", m_wr_data, wr_data[mo]);
        end
        chk("m_rd_avalid", m_rd_avalid, e_rreq ? rd_avalid[mo] : 1'b0);
        if (e_rreq) chk("m_rd_addr", m_rd_addr, rd_addr[mo]);
        chk("m_rd_dready", m_rd_dready, e_rdat ? rd_dready[mo] : 1'b0);
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("p%0d_wr_ready", n), wr_ready_v[n], (e_wreq && mo == n) ? m_wr_ready : 1'b0);
            chk($sformatf("p%0d_rd_aready", n), rd_aready_v[n], (e_rreq && mo == n) ? m_rd_aready : 1'b0);
            chk($sformatf("p%0d_rd_valid", n), rd_valid_v[n], (e_rdat && mo == n) ? m_rd_valid : 1'b0);
        end
        chk("p0_rd_data", p0_rd_data, m_rd_data);
        chk("p1_rd_data", p1_rd_data, m_rd_data);

        if (busy === 1'b1 && busy_prev !== 1'b1) gq.push_back(int'(grant));
        busy_prev = busy;

        if (rst) begin
            mb = 1'b0; mo = 0; ml = 1'b1;
        end else if (!mb) begin
            p0 = wr_valid[0] | rd_avalid[0];
            p1 = wr_valid[1] | rd_avalid[1];
            if (p0 || p1) begin
                w = (p0 && p1) ? (ml ? 0 : 1) : (p1 ? 1 : 0);
                mo = w; ml = (w == 1); mb = 1'b1;
                mk_read = !wr_valid[w]; ms_acc = 1'b0;
            end
        end else if (!mk_read && !ms_acc) begin
            if (wr_valid[mo] && m_wr_ready) ms_acc = 1'b1;
        end else if (!mk_read) begin
            if (m_wr_ready) begin mb = 1'b0; comps++; end
        end else if (!ms_acc) begin
            if (rd_avalid[mo] && m_rd_aready) ms_acc = 1'b1;
        end else if (rd_dready[mo] && m_rd_valid) begin
            mb = 1'b0; comps++;
        end
    endtask

    // Drive just after the rising edge: requesters drop requests once
    // accepted and, in random mode, raise new ones.
    task automatic drive();
        @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++) begin
            if (rst_s) waiting[n] = 1'b0;
            if (wr_hs[n]) wr_valid[n] = 1'b0;
            if (rd_ahs[n]) begin rd_avalid[n] = 1'b0; waiting[n] = 1'b1; end
            if (rd_dhs[n]) waiting[n] = 1'b0;
            if (rnd_mode) begin
                if (!wr_valid[n] && $urandom_range(0, 3) == 0) begin
                    wr_valid[n] = 1'b1;
                    wr_addr[n]  = AW'($urandom) & ~AW'(15);
                    wr_data[n]  = {$urandom, $urandom, $urandom, $urandom};
                end
                if (!rd_avalid[n] && !waiting[n] && $urandom_range(0, 2) == 0) begin
                    rd_avalid[n] = 1'b1;
                    rd_addr[n]   = AW'($urandom) & ~AW'(15);
                end
                rd_dready[n] = ($urandom_range(0, 3) != 0);
            end else if (auto_rd && !rd_avalid[n] && !waiting[n]) begin
                rd_avalid[n] = 1'b1;
                rd_addr[n]   = AW'($urandom) & ~AW'(15);
            end
        end
        if (rnd_mode) begin
            m_wr_ready  = ($urandom_range(0, 9) < 7);
            m_rd_aready = ($urandom_range(0, 9) < 6);
            m_rd_valid  = ($urandom_range(0, 9) < 6);
            m_rd_data   = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic clear_inputs();
        wr_valid = '0; rd_avalid = '0; rd_dready = 2'b11; waiting = '0;
        for (int n = 0; n < 2; n++) begin
            wr_addr[n] = '0; rd_addr[n] = '0; wr_data[n] = '0;
        end
        m_wr_ready = 1'b0; m_rd_aready = 1'b0; m_rd_valid = 1'b0; m_rd_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        sample(); drive();
        sample(); drive();
        rst = 1'b0;
    endtask

    logic [6:0]    busy_obs, mwv_obs, mra_obs, rv_obs;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] rdat;
    logic [7:0]    seq;
    bit            seen;
    int            g0, n;

    initial begin
        rst = 1'b1;
        rst_s = 1'b1;
        wr_hs = '0; rd_ahs = '0; rd_dhs = '0;
        clear_inputs();

        // Reset state
        do_reset();
        sample();
        chk("reset busy", busy, 1'b0);
        chk("reset grant", grant, 1'b0);
        chk("reset m valids", {m_wr_valid, m_rd_avalid, m_rd_dready}, 3'b000);
        chk("reset port readys", {wr_ready_v, rd_aready_v, rd_valid_v}, 6'b0);
        drive();

        // Write then refill on port 0
        wr_valid[0] = 1'b1; wr_addr[0] = 27'h0000120; wr_data[0] = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        rd_avalid[0] = 1'b1; rd_addr[0] = 27'h0000340;
        m_wr_ready = 1'b1; m_rd_aready = 1'b1; m_rd_valid = 1'b1;
        m_rd_data = 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF;
        wa = '0; ra = '0; rdat = '0;
        for (int k = 0; k < 7; k++) begin
            sample();
            busy_obs = {busy_obs[5:0], busy};
            mwv_obs  = {mwv_obs[5:0], m_wr_valid};
            mra_obs  = {mra_obs[5:0], m_rd_avalid};
            rv_obs   = {rv_obs[5:0], p0_rd_valid};
            if (m_wr_valid) wa = m_wr_addr;
            if (m_rd_avalid) ra = m_rd_addr;
            if (p0_rd_valid) rdat = p0_rd_data;
            drive();
        end
        chk("t1 busy trace", busy_obs, 7'b0110110);
        chk("t1 m_wr_valid trace", mwv_obs, 7'b0100000);
        chk("t1 m_rd_avalid trace", mra_obs, 7'b0000100);
        chk("t1 p0_rd_valid trace", rv_obs, 7'b0000010);
        chk("t1 write addr", wa, 27'h0000120);
        chk("t1 read addr", ra, 27'h0000340);
        chk("t1 read data", rdat, 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF);

        // Contention after reset
        do_reset();
        g0 = gq.size();
        rd_avalid = 2'b11; rd_addr[0] = 27'h0000500; rd_addr[1] = 27'h0000600;
        m_rd_aready = 1'b1; m_rd_valid = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 7; k++) begin
            sample();
            busy_obs = {busy_obs[5:0], busy};
            if (k < 3 && p1_rd_valid) seen = 1'b1;
            drive();
        end
        chk("t2 p1 rd_valid during p0", seen, 1'b0);
        chk("t2 busy trace", busy_obs, 7'b0110110);
        chk("t2 grant count", gq.size() - g0, 2);
        if (gq.size() >= g0 + 2) begin
            chk("t2 first grant", gq[g0], 0);
            chk("t2 second grant", gq[g0 + 1], 1);
        end

        // Fairness under continuous reads
        do_reset();
        g0 = gq.size();
        auto_rd = 1'b1;
        m_rd_aready = 1'b1; m_rd_valid = 1'b1;
        n = 0;
        while (gq.size() - g0 < 8 && n < 200) begin
            drive();
            sample();
            n++;
        end
        auto_rd = 1'b0;
        chk("t3 eight grants within budget", (gq.size() - g0 >= 8), 1'b1);
        seq = '0;
        if (gq.size() - g0 >= 8) begin
            for (int i = 0; i < 8; i++) seq = {seq[6:0], 1'(gq[g0 + i])};
            chk("t3 grant sequence", seq, 8'b01010101);
        end
        drive();

        // Slow master: read address held off 5 cycles
        do_reset();
        rd_avalid[1] = 1'b1; rd_addr[1] = 27'h0005550;
        sample();
        chk("t4 idle before grant", busy, 1'b0);
        drive();
        for (int k = 1; k <= 5; k++) begin
            sample();
            chk("t4 m_rd_avalid held", m_rd_avalid, 1'b1);
            chk("t4 m_rd_addr stable", m_rd_addr, 27'h0005550);
            chk("t4 p1_rd_aready low", p1_rd_aready, 1'b0);
            drive();
            if (k == 5) m_rd_aready = 1'b1;
        end
        sample();
        chk("t4 p1_rd_aready pulse", p1_rd_aready, 1'b1);
        drive();
        m_rd_aready = 1'b0; m_rd_valid = 1'b1; m_rd_data = 128'h5A5A;
        sample();
        chk("t4 p1_rd_aready after hs", p1_rd_aready, 1'b0);
        chk("t4 p1_rd_valid", p1_rd_valid, 1'b1);
        drive();
        m_rd_valid = 1'b0;

        // Slow master: write completion held off 10 cycles
        wr_valid[0] = 1'b1; wr_addr[0] = 27'h0000880; wr_data[0] = 128'hC0FFEE;
        m_wr_ready = 1'b1;
        sample();
        chk("t4w idle before grant", busy, 1'b0);
        drive();
        sample();
        chk("t4w write accepted", {m_wr_valid, p0_wr_ready}, 2'b11);
        drive();
        m_wr_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            sample();
            chk("t4w waiting busy", busy, 1'b1);
            chk("t4w waiting m_wr_valid", m_wr_valid, 1'b0);
            drive();
        end
        m_wr_ready = 1'b1;
        sample();
        chk("t4w completing busy", busy, 1'b1);
        drive();
        sample();
        chk("t4w done busy", busy, 1'b0);
        drive();

        // Reset while waiting in R_DATA
        do_reset();
        rd_avalid[0] = 1'b1; rd_addr[0] = 27'h0007770; m_rd_aready = 1'b1;
        sample(); drive();
        sample(); drive();
        sample();
        chk("t5 in read data", {busy, grant}, 2'b10);
        drive();
        rst = 1'b1;
        sample(); drive();
        rst = 1'b0;
        sample();
        chk("t5 busy after reset", busy, 1'b0);
        chk("t5 m valids after reset", {m_wr_valid, m_rd_avalid, m_rd_dready}, 3'b000);
        drive();
        g0 = gq.size();
        rd_avalid[1] = 1'b1; rd_addr[1] = 27'h0009990;
        m_rd_valid = 1'b1; m_rd_data = 128'h1234_5678;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sample();
            if (p1_rd_valid) begin
                seen = 1'b1;
                chk("t5 p1 read data", p1_rd_data, 128'h1234_5678);
            end
            drive();
        end
        chk("t5 p1 read completed", seen, 1'b1);
        chk("t5 grant logged", gq.size() - g0, 1);
        if (gq.size() > g0) chk("t5 granted port", gq[g0], 1);

        // Randomized traffic with occasional reset
        do_reset();
        rnd_mode = 1'b1;
        comps = 0;
        for (int c = 0; c < 3000; c++) begin
            sample();
            drive();
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                wr_valid = '0; rd_avalid = '0;
            end
        end
        rnd_mode = 1'b0;
        chk("random phase made progress", (comps > 100), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
